// File: rtl/taxi_stats_event_collect_if.sv
// AXI4-Stream signal bundle used on the statistics increment path.
// Sideband widths are parameters; the collector drives tkeep/tlast/tdest as constants.
interface taxi_axis_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = (DATA_W + 7) / 8,
    parameter int ID_W   = 8,
    parameter int DEST_W = 8,
    parameter int USER_W = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport snk (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/taxi_stats_event_collect.sv
// Sums per-channel event increments into 16-bit accumulators and emits each nonzero
// accumulator as one AXI-Stream increment record on half scale or on a periodic sweep.
module taxi_stats_event_collect #(
    parameter int CNT           = 8,
    parameter int INC_W         = 4,
    parameter int ID_BASE       = 0,
    parameter int UPDATE_PERIOD = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT*INC_W-1:0] stat_inc,
    taxi_axis_if.src             m_axis_stat,
    output logic [CNT-1:0]       stat_overflow
);
    localparam int PTR_W = (CNT > 1) ? $clog2(CNT) : 1;
    localparam int TMR_W = $clog2(UPDATE_PERIOD);
    localparam int SWL_W = $clog2(CNT + 1);

    // Record handshake: a record is offered while tvalid=1 and transfers on the first
    // cycle with tvalid && tready; tdata/tid stay frozen and tvalid stays high until then.
    typedef enum logic {SCAN, SEND} state_t;
    state_t state, state_next;

    logic [1:0]       rst_sync;
    logic             run;
    logic [15:0]      acc [CNT];
    logic [16:0]      sum [CNT];
    logic [15:0]      acc_sel;
    logic [15:0]      snapshot;
    logic [9:0]       tid_q;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [TMR_W-1:0] timer;
    logic             wrap;
    logic             sweep_active;
    logic [SWL_W-1:0] sweep_left;
    logic             load;
    logic             advance;
    logic             hs;

    // Assert asynchronously, release two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign run = rst_sync[1];

    assign acc_sel = acc[ptr];
    assign ptr_inc = (ptr == PTR_W'(CNT - 1)) ? '0 : ptr + 1'b1;
    assign wrap    = (timer == TMR_W'(UPDATE_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    state <= SCAN;
        else if (!run) state <= SCAN;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        hs         = 1'b0;
        case (state)
            SCAN: begin
                if (acc_sel != 16'd0 && (acc_sel[15] || sweep_active)) begin
                    load       = 1'b1;
                    state_next = SEND;
                end else begin
                    advance = 1'b1;
                end
            end
            SEND: begin
                if (m_axis_stat.tready) begin
                    hs         = 1'b1;
                    advance    = 1'b1;
                    state_next = SCAN;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // The accepted snapshot never exceeds acc, so the 17-bit sum cannot go negative.
    always_comb begin
        for (int n = 0; n < CNT; n++) begin
            sum[n] = {1'b0, acc[n]} + 17'(stat_inc[n*INC_W +: INC_W]);
            if (hs && ptr == PTR_W'(n)) sum[n] = sum[n] - {1'b0, snapshot};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < CNT; n++) acc[n] <= 16'd0;
            stat_overflow <= '0;
        end else if (!run) begin
            for (int n = 0; n < CNT; n++) acc[n] <= 16'd0;
            stat_overflow <= '0;
        end else begin
            for (int n = 0; n < CNT; n++) begin
                acc[n]           <= sum[n][16] ? 16'hFFFF : sum[n][15:0];
                stat_overflow[n] <= sum[n][16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer        <= '0;
            sweep_active <= 1'b0;
            sweep_left   <= '0;
        end else if (!run) begin
            timer        <= '0;
            sweep_active <= 1'b0;
            sweep_left   <= '0;
        end else begin
            timer <= wrap ? '0 : timer + 1'b1;
            if (wrap) begin
                sweep_active <= 1'b1;
                sweep_left   <= SWL_W'(CNT);
            end else if (advance && sweep_active) begin
                sweep_left <= sweep_left - 1'b1;
                if (sweep_left == SWL_W'(1)) sweep_active <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            snapshot <= 16'd0;
            tid_q    <= 10'd0;
        end else if (!run) begin
            ptr      <= '0;
            snapshot <= 16'd0;
            tid_q    <= 10'd0;
        end else begin
            if (load) begin
                snapshot <= acc_sel;
                tid_q    <= 10'(ID_BASE) + 10'(ptr);
            end
            if (advance) ptr <= ptr_inc;
        end
    end

    assign m_axis_stat.tvalid = (state == SEND);
    assign m_axis_stat.tdata  = snapshot;
    assign m_axis_stat.tid    = tid_q;
    assign m_axis_stat.tuser  = '0;
    assign m_axis_stat.tkeep  = '1;
    assign m_axis_stat.tlast  = 1'b1;
    assign m_axis_stat.tdest  = '0;
endmodule
